// File: rtl/seconds_display_mux.sv
// Seconds display mux: 6-bit binary seconds -> two BCD digits -> multiplexed 7-segment drive.
// Latency: a legal value v commits floor(v/10)+1 cycles after the accepting edge; the scan runs freely.
// Backpressure: none; samples arriving while busy are dropped. Build option LEADING_ZERO_BLANK_EN blanks a zero tens digit.
module seconds_display_mux #(
  parameter int SCAN_BITS = 10
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       sample,
  input  logic [5:0] value,
  output logic [6:0] seg,
  output logic [1:0] digit_en,
  output logic       dp,
  output logic       busy,
  output logic       range_err
);

  typedef enum logic {IDLE, CONV} state_t;

  localparam logic [SCAN_BITS-1:0] SCAN_ONE = {{(SCAN_BITS-1){1'b0}}, 1'b1};
  localparam logic [6:0]           SEG_DASH = 7'h40;

  state_t                 state_q, state_d;
  logic [5:0]             work_q, work_d;
  logic [2:0]             acc_tens_q, acc_tens_d;
  logic [2:0]             disp_tens_q, disp_tens_d;
  logic [3:0]             disp_ones_q, disp_ones_d;
  logic                   err_q, err_d;
  logic                   dp_q, dp_d;
  logic [SCAN_BITS-1:0]   scan_cnt_q;
  logic                   dig_q;
  logic [3:0]             digit_sel;

  function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  // Conversion FSM and display registers; reset aborts any conversion in flight.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      work_q      <= '0;
      acc_tens_q  <= '0;
      disp_tens_q <= '0;
      disp_ones_q <= '0;
      err_q       <= 1'b0;
      dp_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      work_q      <= work_d;
      acc_tens_q  <= acc_tens_d;
      disp_tens_q <= disp_tens_d;
      disp_ones_q <= disp_ones_d;
      err_q       <= err_d;
      dp_q        <= dp_d;
    end
  end

  // Next state: accept in IDLE, repeated subtract-10 in CONV, commit all digits at once.
  always_comb begin
    state_d     = state_q;
    work_d      = work_q;
    acc_tens_d  = acc_tens_q;
    disp_tens_d = disp_tens_q;
    disp_ones_d = disp_ones_q;
    err_d       = err_q;
    dp_d        = dp_q;
    case (state_q)
      IDLE: begin
        if (sample) begin
          if (value <= 6'd59) begin
            work_d     = value;
            acc_tens_d = '0;
            state_d    = CONV;
          end else begin
            // Out-of-range: flag only, the shown digits and dp stay as they were.
            err_d = 1'b1;
          end
        end
      end
      CONV: begin
        if (work_q >= 6'd10) begin
          work_d     = work_q - 6'd10;
          acc_tens_d = acc_tens_q + 3'd1;
        end else begin
          disp_tens_d = acc_tens_q;
          disp_ones_d = work_q[3:0];
          err_d       = 1'b0;
          dp_d        = ~dp_q;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Free-running digit scan, independent of the conversion FSM.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      scan_cnt_q <= '0;
      dig_q      <= 1'b0;
    end else begin
      scan_cnt_q <= scan_cnt_q + SCAN_ONE;
      if (scan_cnt_q == '1) begin
        dig_q <= ~dig_q;
      end
    end
  end

  // Segment decode of the currently scanned digit, straight from registers.
  always_comb begin
    digit_sel = dig_q ? {1'b0, disp_tens_q} : disp_ones_q;
    seg       = bcd_to_seg(digit_sel);
`ifdef LEADING_ZERO_BLANK_EN
    if (dig_q && (disp_tens_q == 3'd0)) begin
      seg = 7'h00;
    end
`endif
    if (err_q) begin
      seg = SEG_DASH;
    end
  end

  assign digit_en  = dig_q ? 2'b10 : 2'b01;
  assign busy      = (state_q == CONV);
  assign dp        = dp_q;
  assign range_err = err_q;

endmodule

// File: tb/tb_seconds_display_mux.sv
// Bench for seconds_display_mux with a 2-bit scan prescaler.
// Reference model tracks the shown tens/ones, error flag and dp from plain div/mod arithmetic.
// Scan phase is predicted from the cycle count since reset release.
module tb_seconds_display_mux;

  localparam int SB = 2;

  logic       clock;
  logic       reset;
  logic       sample;
  logic [5:0] value;
  logic [6:0] seg;
  logic [1:0] digit_en;
  logic       dp;
  logic       busy;
  logic       range_err;

  int n_checks = 0;
  int n_errors = 0;
  int cyc;

  // model state
  int   m_tens;
  int   m_ones;
  logic m_err;
  logic m_dp;
  logic [6:0] lut [0:9];

  seconds_display_mux #(.SCAN_BITS(SB)) dut (
    .clock     (clock),
    .reset     (reset),
    .sample    (sample),
    .value     (value),
    .seg       (seg),
    .digit_en  (digit_en),
    .dp        (dp),
    .busy      (busy),
    .range_err (range_err)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // clocks seen since reset release
  always @(posedge clock or negedge reset) begin
    if (!reset) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic exp_dig();
    return ((cyc >> SB) & 1) != 0;
  endfunction

  function automatic logic [6:0] exp_seg();
    if (m_err) return 7'h40;
    if (exp_dig()) begin
`ifdef LEADING_ZERO_BLANK_EN
      if (m_tens == 0) return 7'h00;
`endif
      return lut[m_tens];
    end
    return lut[m_ones];
  endfunction

  task automatic model_reset();
    m_tens = 0;
    m_ones = 0;
    m_err  = 1'b0;
    m_dp   = 1'b0;
  endtask

  // observe both scan phases while idle
  task automatic check_disp(input int ncyc);
    for (int k = 0; k < ncyc; k++) begin
      chk("digit_en", 32'(digit_en), exp_dig() ? 32'd2 : 32'd1);
      chk("seg", 32'(seg), 32'(exp_seg()));
      chk("busy_idle", 32'(busy), 32'd0);
      chk("dp", 32'(dp), 32'(m_dp));
      chk("range_err", 32'(range_err), 32'(m_err));
      step();
    end
  endtask

  task automatic do_sample(input int v);
    int n;
    sample = 1'b1;
    value  = 6'(v);
    step();
    sample = 1'b0;
    if (v <= 59) begin
      n = 0;
      while (busy && n < 100) begin
        n++;
        step();
      end
      chk("busy_len", 32'(n), 32'(v / 10 + 1));
      m_tens = v / 10;
      m_ones = v % 10;
      m_err  = 1'b0;
      m_dp   = ~m_dp;
    end else begin
      chk("busy_err", 32'(busy), 32'd0);
      m_err = 1'b1;
    end
    chk("range_err_post", 32'(range_err), 32'(m_err));
    chk("dp_post", 32'(dp), 32'(m_dp));
    check_disp(8);
  endtask

  initial begin
    int n;
    int v;
    lut[0] = 7'h3F; lut[1] = 7'h06; lut[2] = 7'h5B; lut[3] = 7'h4F; lut[4] = 7'h66;
    lut[5] = 7'h6D; lut[6] = 7'h7D; lut[7] = 7'h07; lut[8] = 7'h7F; lut[9] = 7'h6F;
    model_reset();
    reset  = 1'b0;
    sample = 1'b0;
    value  = '0;

    // reset state
    #12;
    chk("rst_seg", 32'(seg), 32'h3F);
    chk("rst_digit_en", 32'(digit_en), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_range_err", 32'(range_err), 32'd0);
    chk("rst_dp", 32'(dp), 32'd0);
    #5 reset = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) step();
    chk("scan_toggle", 32'(digit_en), 32'd2);
`ifdef LEADING_ZERO_BLANK_EN
    chk("scan_tens_seg", 32'(seg), 32'h00);
`else
    chk("scan_tens_seg", 32'(seg), 32'h3F);
`endif
    check_disp(4);

    // 47 -> 4/7
    do_sample(47);

    // 59 then 12 while busy: 12 must be dropped
    sample = 1'b1;
    value  = 6'd59;
    step();
    sample = 1'b0;
    n = 0;
    while (busy && n < 100) begin
      n++;
      if (n == 2) begin
        sample = 1'b1;
        value  = 6'd12;
      end else begin
        sample = 1'b0;
      end
      step();
    end
    sample = 1'b0;
    chk("busy_len_59", 32'(n), 32'd6);
    m_tens = 5;
    m_ones = 9;
    m_dp   = ~m_dp;
    check_disp(8);

    // out of range, then recovery with 0
    do_sample(62);
    do_sample(0);

    // reset on the 3rd CONV cycle of 38
    sample = 1'b1;
    value  = 6'd38;
    step();
    sample = 1'b0;
    step();
    step();
    chk("conv3_busy", 32'(busy), 32'd1);
    reset = 1'b0;
    #1;
    model_reset();
    chk("midrst_seg", 32'(seg), 32'h3F);
    chk("midrst_digit_en", 32'(digit_en), 32'd1);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_range_err", 32'(range_err), 32'd0);
    chk("midrst_dp", 32'(dp), 32'd0);
    #2 reset = 1'b1;
    step();
    check_disp(8);

    // sweep every legal value
    for (int s = 0; s <= 59; s++) do_sample(s);

    // random values (including illegal) with random idle gaps
    for (int r = 0; r < 40; r++) begin
      v = int'($urandom_range(0, 63));
      do_sample(v);
      for (int g = 0; g < int'($urandom_range(0, 3)); g++) step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/seconds_display_mux.md
Name: seconds_display_mux

Overview:
- Consumer end of the seconds-counter output. Accepts a 6-bit binary seconds value with a one-cycle strobe.
- Converts the value to two BCD digits with a sequential subtract-10 FSM.
- Drives a time-multiplexed, two-digit 7-segment display: one shared segment bus plus one-hot digit enables.
- Sits between the clock core and the uo_out pins.

Parameters:
- SCAN_BITS, 10, width of the digit-scan prescaler; the active digit alternates every 2^SCAN_BITS clocks.

Ports:
- clock  input  1  system clock; all state is updated on the rising edge.
- reset  input  1  asynchronous, active-low.
- sample  input  1  one-cycle strobe: value is valid.
- value  input  6  binary seconds; 0..59 legal.
- seg  output  7  active-high segments {g,f,e,d,c,b,a}; bit0 = a.
- digit_en  output  2  one-hot; [0] = ones digit, [1] = tens digit.
- dp  output  1  colon/decimal point; toggles on each accepted legal sample.
- busy  output  1  high while a conversion is in progress.
- range_err  output  1  last accepted sample was > 59.

Behaviour:
- Clock and reset: reset is asynchronous, active-low; the clock is clock.
- Reset values:
  - state = IDLE; busy = 0; range_err = 0; dp = 0.
  - Display registers tens = 0, ones = 0.
  - Scan counter = 0; digit_en = 2'b01.
  - seg = 7'h3F (ones digit showing "0").
- Registers: work[5:0], acc_tens[2:0], disp_tens[2:0], disp_ones[3:0], err_r, scan_cnt[SCAN_BITS-1:0], dig_r.
- FSM state IDLE:
  - sample=1 and value<=59: work <= value, acc_tens <= 0, state -> CONV; busy = 1 from the next cycle.
  - sample=1 and value>59: err_r <= 1 next cycle; display registers unchanged; dp unchanged; stays IDLE.
  - sample=0: hold.
- FSM state CONV, evaluated each cycle:
  - work>=10: work <= work-10, acc_tens <= acc_tens+1.
  - Otherwise: disp_tens <= acc_tens, disp_ones <= work, err_r <= 0, dp <= ~dp, state -> IDLE.
- Latency: a legal value v spends floor(v/10)+1 cycles in CONV. The new digits are visible the cycle after the final CONV cycle. For v=0 that is 1 CONV cycle; for v=59 it is 6 CONV cycles.
- busy = (state==CONV), registered-state decode.
- sample while busy: ignored entirely. No queueing; range_err is not updated.
- Arithmetic: work never underflows, because the subtract is gated by work>=10. acc_tens is at most 5 for legal inputs.
- Scan:
  - scan_cnt increments every cycle and wraps.
  - When scan_cnt == all-ones, dig_r toggles.
  - digit_en = dig_r ? 2'b10 : 2'b01.
  - The scan runs independently of the FSM, including during CONV.
- Segment decode (combinational from registers):
  - Selected digit is disp_ones or {0, disp_tens}.
  - Digit codes 0..9 → 3F, 06, 5B, 4F, 66, 6D, 7D, 07, 7F, 6F.
  - If err_r=1: both digits show a dash, 7'h40.
- Display registers change only at commit, so no partial value is ever shown.
- Reset mid-conversion: the FSM aborts immediately and all registers return to reset values.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined: when the tens digit is selected, disp_tens==0 and err_r==0, seg = 7'h00 (blank).
- Undefined: the tens digit shows "0" (7'h3F).
- The ones digit and the err dash are unaffected in both builds.

Test Plan:
- Reset with SCAN_BITS=2 -> seg=3F, digit_en=01, busy=0, range_err=0, dp=0. After 4 clocks digit_en=10 and seg=3F; with LEADING_ZERO_BLANK_EN defined, seg=00 instead.
- sample with value=47 -> busy high for exactly 5 cycles; then disp_tens=4, disp_ones=7, dp=1. The ones phase shows seg=07, the tens phase shows seg=66.
- sample with value=59, then sample with value=12 two cycles later (while busy) -> second sample ignored; display shows 5/9 (6D/6F) after 6 CONV cycles; dp toggles once only.
- sample with value=62 -> range_err=1 next cycle; both digits show 40; busy stays 0; dp unchanged. A following sample with value=0 gives range_err=0 and seg=3F after 1 CONV cycle.
- Assert reset on the 3rd CONV cycle of value=38 -> all outputs return to reset values immediately. After release, the display shows 00 and the FSM is IDLE.
- Samples 0 through 59 in sequence, each waiting for busy=0 -> each committed digit pair equals (v/10, v%10); dp alternates on each sample; range_err stays 0.
